// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the M-extension execute unit: op codes, FSM states,
// forward-select encodings and per-op signedness helpers.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;

    // Context kept from acceptance to the FIX cycle.
    typedef struct packed {
        op_e  op;
        logic neg_a;
        logic neg_b;
    } op_ctx_t;

    function automatic logic op_a_signed(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide on
// magnitudes, one bit per cycle, plus the step counter.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_mag_i,
    input  logic [XLEN-1:0]   b_mag_i,
    output logic              last_o,
    output logic [2*XLEN-1:0] acc_o
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic [XLEN:0]     addend, mul_sum, shifted, trial;

    // Multiply: product builds in the upper half while the multiplier shifts
    // out of the lower half. Divide: upper half is the partial remainder,
    // lower half collects quotient bits.
    always_comb begin
        addend  = acc_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + addend;
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial   = shifted - {1'b0, opnd_q};
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (start_i) begin
            acc_d  = {{XLEN{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
            opnd_d = is_div_i ? b_mag_i : a_mag_i;
            cnt_d  = '0;
            div_d  = is_div_i;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q)
                acc_d = {(trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0]),
                         acc_q[XLEN-2:0], ~trial[XLEN]};
            else
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign last_o = (cnt_q == CW'(XLEN - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/ex_muldiv.sv
// M-extension execute unit: operand forwarding, control FSM, special-case
// short-cuts and final sign/half selection around the iterative core.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    input  logic [XLEN-1:0] forwarding_EX_MEM,
    input  logic [XLEN-1:0] forwarding_MEM_WB,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            stall
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    op_ctx_t           ctx_q, ctx_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   op_a, op_b, a_mag, b_mag, special_res, fix_res;
    logic [2*XLEN-1:0] acc, prod_s;
    logic              accept, special, neg_a, neg_b, last, div_zero;
    op_e               op;

    if (FWD_EN) begin : g_fwd
        always_comb begin
            if (ForwardA == FWD_EX_MEM)      op_a = forwarding_EX_MEM;
            else if (ForwardA == FWD_MEM_WB) op_a = forwarding_MEM_WB;
            else                             op_a = read_data_1;
            if (ForwardB == FWD_EX_MEM)      op_b = forwarding_EX_MEM;
            else if (ForwardB == FWD_MEM_WB) op_b = forwarding_MEM_WB;
            else                             op_b = read_data_2;
        end
    end else begin : g_nofwd
        assign op_a = read_data_1;
        assign op_b = read_data_2;
    end

    assign op       = op_e'(funct3);
    assign neg_a    = op_a_signed(op) & op_a[XLEN-1];
    assign neg_b    = op_b_signed(op) & op_b[XLEN-1];
    assign a_mag    = neg_a ? -op_a : op_a;
    assign b_mag    = neg_b ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign special  = funct3[2] &
                      (div_zero | (!funct3[0] && op_a == MIN_NEG && op_b == '1));
    // funct3[1] distinguishes REM* from DIV* within the divide group.
    assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : op_a);
    assign accept   = in_valid & (state_q == S_IDLE) & ~flush;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept & ~special),
        .step_i   (state_q == S_CALC),
        .is_div_i (funct3[2]),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .last_o   (last),
        .acc_o    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (flush) state_d = S_IDLE; else if (last) state_d = S_FIX;
            S_FIX:   state_d = flush ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        stall     = rst_n & (accept | (state_q == S_CALC) | (state_q == S_FIX));
    end

    always_comb begin
        prod_s  = (ctx_q.neg_a ^ ctx_q.neg_b) ? -acc : acc;
        fix_res = '0;
        case (ctx_q.op)
            OP_MUL:                        fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = (ctx_q.neg_a ^ ctx_q.neg_b) ?
                                                     -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                       fix_res = ctx_q.neg_a ?
                                                     -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
        ctx_d    = ctx_q;
        result_d = result_q;
        if (accept) ctx_d = '{op: op, neg_a: neg_a, neg_b: neg_b};
        if (accept && special)                  result_d = special_res;
        else if (state_q == S_FIX && !flush)    result_d = fix_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q    <= '{op: OP_MUL, neg_a: 1'b0, neg_b: 1'b0};
            result_q <= '0;
        end else begin
            ctx_q    <= ctx_d;
            result_q <= result_d;
        end
    end

    assign out_result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv (XLEN=32) with an arithmetic
// reference model and a per-cycle timing/result monitor.
module tb_ex_muldiv;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rd1 = '0, rd2 = '0, fex = '0, fwb = '0;
    logic [1:0]  fa = 2'b00, fb = 2'b00;
    logic        in_ready, out_valid, stall;
    logic [31:0] out_result;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;

    ex_muldiv #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .read_data_1(rd1), .read_data_2(rd2),
        .ForwardA(fa), .ForwardB(fb), .forwarding_EX_MEM(fex),
        .forwarding_MEM_WB(fwb), .flush(flush), .out_valid(out_valid),
        .out_result(out_result), .stall(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] sel(input logic [1:0] f, input logic [31:0] r,
                                        input logic [31:0] ex, input logic [31:0] wb);
        if (f == 2'b10) return ex;
        if (f == 2'b01) return wb;
        return r;
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = 64'(a) * 64'(b); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    // Monitor: the model tracks one op in flight by cycle numbers only.
    bit          pend = 1'b0;
    int          due = 0;
    logic [31:0] held = '0, nres = '0;
    always @(negedge clk) begin
        bit busy, acc;
        logic [31:0] a, b;
        if (!rst_n) begin
            pend = 1'b0;
            held = '0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_stall", stall, 0);
            chk("rst_out_result", out_result, 0);
        end else begin
            busy = pend && (cyc <= due);
            acc  = in_valid && !flush && !busy;
            chk("mon_in_ready", in_ready, !busy);
            chk("mon_out_valid", out_valid, busy && cyc == due);
            chk("mon_stall", stall, acc || (busy && cyc < due));
            chk("mon_out_result", out_result, (busy && cyc == due) ? nres : held);
            if (busy && cyc == due) begin
                held = nres;
                pend = 1'b0;
            end else if (busy && flush) begin
                pend = 1'b0;
            end
            if (acc) begin
                a    = sel(fa, rd1, fex, fwb);
                b    = sel(fb, rd2, fex, fwb);
                nres = ref_res(funct3, a, b);
                due  = cyc + ref_lat(funct3, a, b);
                pend = 1'b1;
            end
        end
    end

    // flush_at: -1 none, 0 with the request, n>0 in the n-th cycle after it.
    // exp_lat: >0 expected latency, 0 expect no result, -1 monitor only.
    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] xa, input logic [1:0] xb,
                       input logic [31:0] vex, input logic [31:0] vwb,
                       input int flush_at, input int exp_lat,
                       input logic [31:0] exp_res, input string nm);
        int got;
        logic [31:0] res;
        got = 0;
        res = '0;
        @(posedge clk); #1;
        funct3 = f; rd1 = a; rd2 = b; fa = xa; fb = xb; fex = vex; fwb = vwb;
        in_valid = 1'b1;
        flush = (flush_at == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            flush = (n == flush_at);
            @(negedge clk);
            if (exp_lat == 0 && n == flush_at + 1) begin
                chk({nm, "_stall_after_flush"}, stall, 0);
                chk({nm, "_ready_after_flush"}, in_ready, 1);
            end
            if (out_valid && got == 0) begin
                got = n;
                res = out_result;
            end
            @(posedge clk); #1;
            flush = 1'b0;
            if (got != 0) break;
        end
        if (exp_lat > 0) begin
            chk({nm, "_latency"}, got, exp_lat);
            chk({nm, "_result"}, res, exp_res);
        end else if (exp_lat == 0) begin
            chk({nm, "_no_result"}, got, 0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int got;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_mulhu", ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        chk("model_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_div_ovf", ref_res(3'd4, MINV, 32'hFFFF_FFFF), MINV);

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 2'b00, 2'b00, 0, 0, -1, 34, 32'hFFFF_FFEB, "mul_7x-3");
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, -1, 34, 32'hFFFF_FFFE, "mulhu");
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b00, 0, 0, -1, 34, 32'hFFFF_FFFF, "mulhsu");
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 0, 0, -1, 34, 32'hFFFF_FFFD, "div_-7_2");
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 0, 0, -1, 34, 32'hFFFF_FFFF, "rem_-7_2");
        run(3'd5, 32'd5, 32'd0, 2'b00, 2'b00, 0, 0, -1, 1, 32'hFFFF_FFFF, "divu_by0");
        run(3'd7, 32'd5, 32'd0, 2'b00, 2'b00, 0, 0, -1, 1, 32'd5, "remu_by0");
        run(3'd4, MINV, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, -1, 1, MINV, "div_ovf");
        run(3'd6, MINV, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, -1, 1, 32'd0, "rem_ovf");
        run(3'd0, 32'd100, 32'd200, 2'b10, 2'b01, 32'd6, 32'd4, -1, 34, 32'd24, "fwd_mul");
        run(3'd0, 32'd9, 32'd9, 2'b00, 2'b00, 0, 0, 5, 0, 32'd0, "flush_calc");
        run(3'd0, 32'd9, 32'd9, 2'b00, 2'b00, 0, 0, 0, 0, 32'd0, "flush_idle");
        run(3'd1, 32'd9, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 34, 34, 32'hFFFF_FFFF, "flush_done");

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        funct3 = 3'd0; rd1 = 32'd3; rd2 = 32'd5; fa = 2'b00; fb = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_stall", stall, 0);
        chk("async_rst_out_result", out_result, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        got = 0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        chk("async_rst_no_result", got, 0);

        for (int i = 0; i < 50; i++) begin
            int fl;
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 35)) : -1;
            run(3'($urandom_range(0, 7)), pick(), pick(),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                pick(), pick(), fl, -1, 32'd0, "rand");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
